chan_ctlr_q: RTL and testbench



---
 rtl/chan_ctlr_q_pkg.sv | 16 +
 rtl/chan_wait_timer.sv | 37 +++
 rtl/chan_ctlr_q.sv | 244 ++++++++++++++++++++++++
 tb/tb_chan_ctlr_q.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_ctlr_q_pkg.sv
// Shared CPU headers for the channel controller: pipeline state code,
// channel command code and the inter-CPU channel message codes.
package chan_ctlr_q_pkg;

    localparam logic [7:0] ALU_BEGIN = 8'h05;
    localparam logic [3:0] CMD_CHN   = 4'hA;

    localparam logic [7:0] CPU_R_CHAN_SET  = 8'h40;
    localparam logic [7:0] CPU_R_CHAN_GET  = 8'h41;
    localparam logic [7:0] CPU_R_CHAN_TST  = 8'h42;
    localparam logic [7:0] CPU_R_CHAN_CRT  = 8'h43;
    localparam logic [7:0] CPU_R_CHAN_DEL  = 8'h44;
    localparam logic [7:0] CPU_R_CHAN_DONE = 8'h45;
    localparam logic [7:0] CPU_R_CHAN_NACK = 8'h46;

endpackage

// File: rtl/chan_wait_timer.sv
// Loadable down-counter shared by the WAIT timeout and the NACK back-off.
// Ports: clk/rst (async active-low), en (edge enable), load/load_val, zero.
module chan_wait_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Free-runs down to zero; callers only look at it after a load.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/chan_ctlr_q.sv
// Channel controller: decodes CMD_CHN ops, talks to the dispatcher with
// retry/back-off/timeout and returns dst/err with a next_state strobe.
// Ports: clk (falling edge), rst (async low), clk_oe, state, command,
// src0/src1, disp_online, cpu_msg_in/data_in (reply), cpu_msg_out,
// cpu_msg_pulse, data_out, addr_out (request), dst, err, next_state.
module chan_ctlr_q
    import chan_ctlr_q_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MSG_W     = 8,
    parameter int STATE_W   = 8,
    parameter int TIMEOUT   = 1024,
    parameter int MAX_RETRY = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_oe,
    input  logic [STATE_W-1:0] state,
    input  logic [31:0]        command,
    input  logic [DATA_W-1:0]  src1,
    input  logic [DATA_W-1:0]  src0,
    input  logic               disp_online,
    input  logic [MSG_W-1:0]   cpu_msg_in,
    output logic [MSG_W-1:0]   cpu_msg_out,
    output logic               cpu_msg_pulse,
    output logic [DATA_W-1:0]  data_out,
    output logic [ADDR_W-1:0]  addr_out,
    input  logic [DATA_W-1:0]  data_in,
    output logic [DATA_W-1:0]  dst,
    output logic               err,
    output logic               next_state
);

    localparam int BO_MAX = 2 ** MAX_RETRY;
    localparam int TW = $clog2((TIMEOUT > BO_MAX) ? TIMEOUT : BO_MAX) + 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TO_LOAD = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SEND, ST_WAIT, ST_BACKOFF, ST_DONE
    } fsm_t;

    typedef enum logic [2:0] {
        OP_XCHG = 3'b000, OP_GET = 3'b001, OP_TST = 3'b010, OP_CRT = 3'b011,
        OP_SET  = 3'b100, OP_IL5 = 3'b101, OP_DEL = 3'b110, OP_IL7 = 3'b111
    } op_t;

    fsm_t              fsm_q, fsm_d;
    op_t               op_q, op_d, op_new;
    logic              phase_q, phase_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [DATA_W-1:0] src0_q, src0_d, src1_q, src1_d;
    logic [DATA_W-1:0] dst_q, dst_d;
    logic              err_q, err_d;
    logic              nxt_q, nxt_d;
    logic              pulse_q, pulse_d;
    logic [MSG_W-1:0]  msg_q, msg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              tmr_load, tmr_zero;
    logic [TW-1:0]     tmr_val;
    logic              start;
    logic              unused_cmd;

    assign unused_cmd = ^{command[27:26], command[19:0]};

    assign start = (state == STATE_W'(ALU_BEGIN))
                 && (command[31:28] == CMD_CHN) && disp_online;
    assign op_new = op_t'({&command[25:24], &command[23:22], &command[21:20]});

    always_comb begin
        fsm_d    = fsm_q;
        op_d     = op_q;
        phase_d  = phase_q;
        retry_d  = retry_q;
        src0_d   = src0_q;
        src1_d   = src1_q;
        dst_d    = dst_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        pulse_d  = 1'b0;
        msg_d    = '0;
        data_d   = '0;
        addr_d   = '0;
        unique case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op_new;
                    src0_d  = src0;
                    src1_d  = src1;
                    err_d   = 1'b0;
                    retry_d = '0;
                    phase_d = 1'b0;
                    if (op_new[2] && op_new[0]) begin
                        err_d = 1'b1;
                        fsm_d = ST_DONE;
                    end else begin
                        fsm_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                fsm_d    = ST_WAIT;
                tmr_load = 1'b1;
                tmr_val  = TO_LOAD;
            end
            ST_WAIT: begin
                if (!disp_online) begin
                    err_d = 1'b1;
                    fsm_d = ST_DONE;
                end else if (cpu_msg_in == MSG_W'(CPU_R_CHAN_DONE)) begin
                    if (op_q == OP_XCHG && !phase_q) begin
                        phase_d = 1'b1;
                        fsm_d   = ST_SEND;
                    end else begin
                        // Ops with a clear top flag bit return data.
                        if (!op_q[2]) begin
                            dst_d = data_in;
                        end
                        fsm_d = ST_DONE;
                    end
                end else if (cpu_msg_in == MSG_W'(CPU_R_CHAN_NACK)) begin
                    if (int'(retry_q) < MAX_RETRY) begin
                        retry_d  = retry_q + RW'(1);
                        fsm_d    = ST_BACKOFF;
                        tmr_load = 1'b1;
                        tmr_val  = (TW'(1) << retry_d) - TW'(1);
                    end else begin
                        err_d = 1'b1;
                        fsm_d = ST_DONE;
                    end
                end else if (TIMEOUT != 0 && tmr_zero) begin
                    err_d = 1'b1;
                    fsm_d = ST_DONE;
                end
            end
            ST_BACKOFF: begin
                if (tmr_zero) begin
                    fsm_d = ST_SEND;
                end
            end
            ST_DONE: begin
                if (state != STATE_W'(ALU_BEGIN)) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase

        // Request bundle is registered on entry to SEND so it lines up
        // with the one-cycle strobe.
        if (fsm_d == ST_SEND && fsm_q != ST_SEND) begin
            pulse_d = 1'b1;
            unique case (op_d)
                OP_XCHG: begin
                    msg_d  = phase_d ? MSG_W'(CPU_R_CHAN_GET)
                                     : MSG_W'(CPU_R_CHAN_SET);
                    data_d = phase_d ? '0 : src1_d;
                    addr_d = ADDR_W'(src0_d);
                end
                OP_GET: begin
                    msg_d  = MSG_W'(CPU_R_CHAN_GET);
                    addr_d = ADDR_W'(src0_d);
                end
                OP_TST: begin
                    msg_d  = MSG_W'(CPU_R_CHAN_TST);
                    addr_d = ADDR_W'(src1_d);
                end
                OP_CRT: msg_d = MSG_W'(CPU_R_CHAN_CRT);
                OP_SET: begin
                    msg_d  = MSG_W'(CPU_R_CHAN_SET);
                    data_d = src1_d;
                    addr_d = ADDR_W'(src0_d);
                end
                OP_DEL: begin
                    msg_d  = MSG_W'(CPU_R_CHAN_DEL);
                    addr_d = ADDR_W'(src1_d);
                end
                default: pulse_d = 1'b0;
            endcase
        end

        nxt_d = (fsm_d == ST_DONE) && (fsm_q != ST_DONE);
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= ST_IDLE;
            op_q    <= OP_XCHG;
            phase_q <= 1'b0;
            retry_q <= '0;
            src0_q  <= '0;
            src1_q  <= '0;
            dst_q   <= '0;
            err_q   <= 1'b0;
            nxt_q   <= 1'b0;
            pulse_q <= 1'b0;
            msg_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
        end else if (clk_oe) begin
            fsm_q   <= fsm_d;
            op_q    <= op_d;
            phase_q <= phase_d;
            retry_q <= retry_d;
            src0_q  <= src0_d;
            src1_q  <= src1_d;
            dst_q   <= dst_d;
            err_q   <= err_d;
            nxt_q   <= nxt_d;
            pulse_q <= pulse_d;
            msg_q   <= msg_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end else begin
            // Disabled edges still retire the strobes and request bundle.
            nxt_q   <= 1'b0;
            pulse_q <= 1'b0;
            msg_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
        end
    end

    chan_wait_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (clk_oe),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign cpu_msg_out   = msg_q;
    assign cpu_msg_pulse = pulse_q;
    assign data_out      = data_q;
    assign addr_out      = addr_q;
    assign dst           = dst_q;
    assign err           = err_q;
    assign next_state    = nxt_q;

endmodule

// File: tb/tb_chan_ctlr_q.sv
// Directed bench for chan_ctlr_q (TIMEOUT=8): GET, timeout, XCHG,
// NACK back-off, illegal op, mid-operation reset and clk_oe gating.
module tb_chan_ctlr_q;
    import chan_ctlr_q_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_oe;
    logic [7:0]  state;
    logic [31:0] command;
    logic [31:0] src1, src0;
    logic        disp_online;
    logic [7:0]  cpu_msg_in;
    logic [7:0]  cpu_msg_out;
    logic        cpu_msg_pulse;
    logic [31:0] data_out;
    logic [31:0] addr_out;
    logic [31:0] data_in;
    logic [31:0] dst;
    logic        err;
    logic        next_state;

    int total = 0;
    int bad = 0;

    chan_ctlr_q #(.TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_oe        (clk_oe),
        .state         (state),
        .command       (command),
        .src1          (src1),
        .src0          (src0),
        .disp_online   (disp_online),
        .cpu_msg_in    (cpu_msg_in),
        .cpu_msg_out   (cpu_msg_out),
        .cpu_msg_pulse (cpu_msg_pulse),
        .data_out      (data_out),
        .addr_out      (addr_out),
        .data_in       (data_in),
        .dst           (dst),
        .err           (err),
        .next_state    (next_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [31:0] mk_cmd(input logic [2:0] op);
        return {CMD_CHN, 2'b00, {2{op[2]}}, {2{op[1]}}, {2{op[0]}}, 20'h0};
    endfunction

    // One active (falling) edge, then sample 1ns later.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic go_idle();
        state      = 8'h00;
        command    = 32'h0;
        cpu_msg_in = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if ({cpu_msg_out, cpu_msg_pulse, data_out, addr_out} !== '0) begin
            bad++;
            $display("FAIL reset_req: got %h/%b/%h/%h want 0", cpu_msg_out,
                     cpu_msg_pulse, data_out, addr_out);
        end
        total++;
        if ({dst, err, next_state} !== '0) begin
            bad++;
            $display("FAIL reset_res: got %h/%b/%b want 0", dst, err, next_state);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_get();
        state   = ALU_BEGIN;
        command = mk_cmd(3'b001);
        src0    = 32'h40;
        src1    = 32'h0;
        tick();
        total++;
        if ({cpu_msg_pulse, cpu_msg_out, addr_out} !== {1'b1, CPU_R_CHAN_GET, 32'h40}) begin
            bad++;
            $display("FAIL get_pulse: got %b/%h/%h want 1/%h/40", cpu_msg_pulse,
                     cpu_msg_out, addr_out, CPU_R_CHAN_GET);
        end
        tick();
        total++;
        if (cpu_msg_pulse !== 1'b0) begin
            bad++;
            $display("FAIL get_pulse_width: got %b want 0", cpu_msg_pulse);
        end
        tick();
        total++;
        if (next_state !== 1'b0) begin
            bad++;
            $display("FAIL get_early_nxt: got %b want 0", next_state);
        end
        cpu_msg_in = CPU_R_CHAN_DONE;
        data_in    = 32'hDEADBEEF;
        tick();
        total++;
        if ({next_state, err, dst} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL get_done: got %b/%b/%h want 1/0/deadbeef", next_state, err, dst);
        end
        cpu_msg_in = 8'h00;
        tick();
        total++;
        if (next_state !== 1'b0) begin
            bad++;
            $display("FAIL get_nxt_width: got %b want 0", next_state);
        end
        go_idle();
    endtask

    task automatic test_timeout();
        logic [11:0] pseq;
        logic [11:0] nseq;
        state   = ALU_BEGIN;
        command = mk_cmd(3'b010);
        src0    = 32'h0;
        src1    = 32'h30;
        for (int i = 0; i < 12; i++) begin
            tick();
            pseq[i] = cpu_msg_pulse;
            nseq[i] = next_state;
            if (i == 0) begin
                total++;
                if ({cpu_msg_out, addr_out} !== {CPU_R_CHAN_TST, 32'h30}) begin
                    bad++;
                    $display("FAIL tst_req: got %h/%h want %h/30", cpu_msg_out,
                             addr_out, CPU_R_CHAN_TST);
                end
            end
        end
        total++;
        if (pseq !== 12'h001) begin
            bad++;
            $display("FAIL tst_pulses: got %b want 000000000001", pseq);
        end
        total++;
        if (nseq !== 12'h200) begin
            bad++;
            $display("FAIL tst_nxt_time: got %b want 001000000000", nseq);
        end
        total++;
        if ({err, dst} !== {1'b1, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL tst_result: got %b/%h want 1/deadbeef", err, dst);
        end
        go_idle();
    endtask

    task automatic test_xchg();
        int nx;
        state   = ALU_BEGIN;
        command = mk_cmd(3'b000);
        src0    = 32'h10;
        src1    = 32'h55;
        tick();
        total++;
        if ({cpu_msg_pulse, cpu_msg_out, data_out, addr_out} !==
            {1'b1, CPU_R_CHAN_SET, 32'h55, 32'h10}) begin
            bad++;
            $display("FAIL xchg_set: got %b/%h/%h/%h want 1/%h/55/10", cpu_msg_pulse,
                     cpu_msg_out, data_out, addr_out, CPU_R_CHAN_SET);
        end
        tick();
        cpu_msg_in = CPU_R_CHAN_DONE;
        data_in    = 32'h99;
        tick();
        total++;
        if ({cpu_msg_pulse, cpu_msg_out, data_out, addr_out, next_state} !==
            {1'b1, CPU_R_CHAN_GET, 32'h0, 32'h10, 1'b0}) begin
            bad++;
            $display("FAIL xchg_get: got %b/%h/%h/%h/%b want 1/%h/0/10/0", cpu_msg_pulse,
                     cpu_msg_out, data_out, addr_out, next_state, CPU_R_CHAN_GET);
        end
        nx = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (next_state) nx++;
            if (i == 1) begin
                total++;
                if ({next_state, dst, err} !== {1'b1, 32'h99, 1'b0}) begin
                    bad++;
                    $display("FAIL xchg_done: got %b/%h/%b want 1/99/0", next_state, dst, err);
                end
            end
        end
        total++;
        if (nx !== 1) begin
            bad++;
            $display("FAIL xchg_nxt_count: got %0d want 1", nx);
        end
        go_idle();
    endtask

    task automatic test_nack();
        logic [13:0] pseq;
        logic [13:0] nseq;
        logic        bundle_ok;
        state     = ALU_BEGIN;
        command   = mk_cmd(3'b100);
        src0      = 32'h20;
        src1      = 32'h77;
        bundle_ok = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 2 || i == 6) cpu_msg_in = CPU_R_CHAN_NACK;
            else if (i == 12) cpu_msg_in = CPU_R_CHAN_DONE;
            else cpu_msg_in = 8'h00;
            tick();
            pseq[i] = cpu_msg_pulse;
            nseq[i] = next_state;
            if (cpu_msg_pulse) begin
                if ({cpu_msg_out, data_out, addr_out} !== {CPU_R_CHAN_SET, 32'h77, 32'h20})
                    bundle_ok = 1'b0;
            end else if ({cpu_msg_out, data_out, addr_out} !== '0) begin
                bundle_ok = 1'b0;
            end
        end
        total++;
        if (pseq !== 14'b00_0100_0001_0001) begin
            bad++;
            $display("FAIL nack_pulses: got %b want 00010000010001", pseq);
        end
        total++;
        if (nseq !== 14'b01_0000_0000_0000) begin
            bad++;
            $display("FAIL nack_nxt: got %b want 01000000000000", nseq);
        end
        total++;
        if (bundle_ok !== 1'b1) begin
            bad++;
            $display("FAIL nack_bundle: got %b want 1", bundle_ok);
        end
        total++;
        if ({err, dst} !== {1'b0, 32'h99}) begin
            bad++;
            $display("FAIL nack_result: got %b/%h want 0/99", err, dst);
        end
        go_idle();
    endtask

    task automatic test_illegal();
        int np;
        int nx;
        state   = ALU_BEGIN;
        command = mk_cmd(3'b101);
        tick();
        total++;
        if ({next_state, err, cpu_msg_pulse} !== 3'b110) begin
            bad++;
            $display("FAIL ill_start: got %b%b%b want 110", next_state, err, cpu_msg_pulse);
        end
        np = 0;
        nx = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_msg_pulse) np++;
            if (next_state) nx++;
        end
        total++;
        if (np + nx !== 0) begin
            bad++;
            $display("FAIL ill_retrigger: got %0d/%0d want 0/0", np, nx);
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        logic quiet;
        state   = ALU_BEGIN;
        command = mk_cmd(3'b001);
        src0    = 32'h44;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({cpu_msg_out, cpu_msg_pulse, data_out, addr_out, dst, err, next_state} !== '0) begin
            bad++;
            $display("FAIL rstmid_now: got dst=%h err=%b want all 0", dst, err);
        end
        cpu_msg_in = CPU_R_CHAN_DONE;
        data_in    = 32'hABCD;
        state      = 8'h00;
        command    = 32'h0;
        quiet      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clk_oe = i[0];
            tick();
            if ({cpu_msg_pulse, dst, err, next_state} !== '0) quiet = 1'b0;
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clk_oe = i[0];
            tick();
            if ({cpu_msg_pulse, dst, err, next_state} !== '0) quiet = 1'b0;
        end
        total++;
        if (quiet !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_quiet: got %b want 1", quiet);
        end
        clk_oe  = 1'b1;
        data_in = 32'h1234;
        state   = ALU_BEGIN;
        command = mk_cmd(3'b001);
        src0    = 32'h50;
        tick();
        total++;
        if ({cpu_msg_pulse, addr_out} !== {1'b1, 32'h50}) begin
            bad++;
            $display("FAIL fresh_pulse: got %b/%h want 1/50", cpu_msg_pulse, addr_out);
        end
        clk_oe = 1'b0;
        tick();
        total++;
        if ({cpu_msg_pulse, addr_out} !== '0) begin
            bad++;
            $display("FAIL oe_pulse_clr: got %b/%h want 0/0", cpu_msg_pulse, addr_out);
        end
        clk_oe = 1'b1;
        tick();
        tick();
        total++;
        if ({next_state, dst, err} !== {1'b1, 32'h1234, 1'b0}) begin
            bad++;
            $display("FAIL fresh_done: got %b/%h/%b want 1/1234/0", next_state, dst, err);
        end
        clk_oe = 1'b0;
        tick();
        total++;
        if ({next_state, dst} !== {1'b0, 32'h1234}) begin
            bad++;
            $display("FAIL oe_nxt_clr: got %b/%h want 0/1234", next_state, dst);
        end
        clk_oe = 1'b1;
        go_idle();
    endtask

    initial begin
        rst         = 1'b0;
        clk_oe      = 1'b1;
        state       = 8'h00;
        command     = 32'h0;
        src0        = 32'h0;
        src1        = 32'h0;
        disp_online = 1'b1;
        cpu_msg_in  = 8'h00;
        data_in     = 32'h0;
        test_reset();
        test_get();
        test_timeout();
        test_xchg();
        test_nack();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
